// File: rtl/ball_centroid_pkg.sv
// Shared widths, RGB565 field positions and FSM encoding for the ball centroid block.
package ball_centroid_pkg;

  localparam int unsigned CntW = 12;
  localparam int unsigned SumW = 20;
  localparam int unsigned PosW = 8;

  // RGB565 field positions
  localparam int unsigned RMsb = 15;
  localparam int unsigned RLsb = 11;
  localparam int unsigned GMsb = 10;
  localparam int unsigned GLsb = 5;
  localparam int unsigned BMsb = 4;
  localparam int unsigned BLsb = 0;

  localparam logic [CntW-1:0] CntMax = '1;

  typedef enum logic [1:0] {
    StAccum,
    StDivX,
    StDivY,
    StHold
  } state_e;

endpackage

// File: rtl/ball_centroid_seq_divider.sv
// Restoring shift-subtract divider: one quotient bit per cycle, SumW cycles per divide.
// o_done is high in the cycle of the final step; o_quotient is then the finished quotient.
module seq_divider
  import ball_centroid_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [SumW-1:0] i_dividend,
  input  logic [CntW-1:0] i_divisor,
  output logic            o_busy,
  output logic            o_done,
  output logic [SumW-1:0] o_quotient
);

  logic [SumW-1:0] r_quo;
  logic [CntW-1:0] r_rem;
  logic [CntW-1:0] r_den;
  logic [4:0]      r_step;
  logic            r_busy;

  logic [CntW:0]   w_shift;
  logic [CntW:0]   w_diff;
  logic            w_ge;
  logic [CntW-1:0] w_rem_next;
  logic [SumW-1:0] w_quo_next;
  logic            w_last;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    w_shift    = {r_rem, r_quo[SumW-1]};
    w_diff     = w_shift - {1'b0, r_den};
    w_ge       = (w_shift >= {1'b0, r_den});
    w_rem_next = w_ge ? w_diff[CntW-1:0] : w_shift[CntW-1:0];
    w_quo_next = {r_quo[SumW-2:0], w_ge};
    w_last     = (r_step == 5'(SumW - 1));
  end

  assign o_busy     = r_busy;
  assign o_done     = r_busy && w_last;
  assign o_quotient = w_quo_next;

  // Divider registers; a start always wins, even in the final-step cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_quo  <= '0;
      r_rem  <= '0;
      r_den  <= '0;
      r_step <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_quo  <= i_dividend;
      r_rem  <= '0;
      r_den  <= i_divisor;
      r_step <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_quo  <= w_quo_next;
      r_rem  <= w_rem_next;
      r_step <= r_step + 5'd1;
      if (w_last) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ball_centroid.sv
// Ball centroid: counts red ball pixels per frame and reports the floor-mean position.
// Accumulation of the next frame runs while the previous frame is divided and held.
module ball_centroid
  import ball_centroid_pkg::*;
#(
  parameter int unsigned LINE_W  = 160,
  parameter logic [4:0]  R_MIN   = 5'd20,
  parameter logic [5:0]  G_MAX   = 6'd24,
  parameter logic [4:0]  B_MAX   = 5'd12,
  parameter logic [11:0] MIN_PIX = 12'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_we,
  input  logic [15:0] pix_data,
  input  logic        frame_start,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_found,
  output logic [7:0]  res_x,
  output logic [7:0]  res_y,
  output logic [11:0] res_count,
  output logic        overrun
);

  localparam logic [PosW-1:0] XLast = 8'(LINE_W - 1);

  state_e r_state, w_state_d;

  logic [PosW-1:0] r_x, r_y, w_x_cur, w_y_cur;
  logic [CntW-1:0] r_cnt, w_cnt_cur;
  logic [SumW-1:0] r_sx, r_sy, w_sx_cur, w_sy_cur;
  logic [SumW-1:0] r_snap_sy;
  logic            r_found, r_overrun;
  logic [7:0]      r_res_x, r_res_y;
  logic [CntW-1:0] r_res_count;
  logic            w_ball;

  logic            w_div_start, w_div_busy, w_div_done;
  logic [SumW-1:0] w_div_dividend, w_div_quo;
  logic [CntW-1:0] w_div_divisor;
  logic            w_unused_div;

  // Ball-pixel test; a frame_start clears the running state before this cycle's pixel.
  always_comb begin
    w_ball    = (pix_data[RMsb:RLsb] >= R_MIN) && (pix_data[GMsb:GLsb] <= G_MAX) &&
                (pix_data[BMsb:BLsb] <= B_MAX);
    w_x_cur   = frame_start ? '0 : r_x;
    w_y_cur   = frame_start ? '0 : r_y;
    w_cnt_cur = frame_start ? '0 : r_cnt;
    w_sx_cur  = frame_start ? '0 : r_sx;
    w_sy_cur  = frame_start ? '0 : r_sy;
  end

  // Position counters and accumulators; all three freeze once the count saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x   <= '0;
      r_y   <= '0;
      r_cnt <= '0;
      r_sx  <= '0;
      r_sy  <= '0;
    end else begin
      r_x   <= w_x_cur;
      r_y   <= w_y_cur;
      r_cnt <= w_cnt_cur;
      r_sx  <= w_sx_cur;
      r_sy  <= w_sy_cur;
      if (pix_we) begin
        if (w_x_cur == XLast) begin
          r_x <= '0;
          r_y <= (w_y_cur == 8'hFF) ? w_y_cur : w_y_cur + 8'd1;
        end else begin
          r_x <= w_x_cur + 8'd1;
        end
        if (w_ball && (w_cnt_cur != CntMax)) begin
          r_cnt <= w_cnt_cur + 12'd1;
          r_sx  <= w_sx_cur + SumW'(w_x_cur);
          r_sy  <= w_sy_cur + SumW'(w_y_cur);
        end
      end
    end
  end

  // Next-state and divider control; x divide uses the live sums, y the snapshot.
  always_comb begin
    w_state_d      = r_state;
    w_div_start    = 1'b0;
    w_div_dividend = r_sx;
    w_div_divisor  = r_cnt;
    case (r_state)
      StAccum: begin
        if (frame_start) begin
          if (r_cnt >= MIN_PIX) begin
            w_state_d   = StDivX;
            w_div_start = 1'b1;
          end else begin
            w_state_d = StHold;
          end
        end
      end
      StDivX: begin
        w_div_dividend = r_snap_sy;
        w_div_divisor  = r_res_count;
        if (w_div_done) begin
          w_state_d   = StDivY;
          w_div_start = 1'b1;
        end
      end
      StDivY: begin
        if (w_div_done) begin
          w_state_d = StHold;
        end
      end
      StHold: begin
        if (res_ready) begin
          w_state_d = StAccum;
        end
      end
      default: w_state_d = StAccum;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StAccum;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Result registers: snapshot on accepted frame_start, quotients as each divide ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_snap_sy   <= '0;
      r_res_count <= '0;
      r_found     <= 1'b0;
      r_res_x     <= '0;
      r_res_y     <= '0;
      r_overrun   <= 1'b0;
    end else begin
      if (frame_start && (r_state != StAccum)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        StAccum: begin
          if (frame_start) begin
            r_snap_sy   <= r_sy;
            r_res_count <= r_cnt;
            r_found     <= (r_cnt >= MIN_PIX);
            r_res_x     <= '0;
            r_res_y     <= '0;
          end
        end
        StDivX: if (w_div_done) r_res_x <= w_div_quo[7:0];
        StDivY: if (w_div_done) r_res_y <= w_div_quo[7:0];
        default: ;
      endcase
    end
  end

  seq_divider u_div (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_div_start),
    .i_dividend (w_div_dividend),
    .i_divisor  (w_div_divisor),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_quotient (w_div_quo)
  );

  // Centroids never exceed 8 bits; the upper quotient bits and busy are not needed here.
  assign w_unused_div = w_div_busy ^ (^w_div_quo[SumW-1:8]);

  assign res_valid = (r_state == StHold);
  assign res_found = r_found;
  assign res_x     = r_res_x;
  assign res_y     = r_res_y;
  assign res_count = r_res_count;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_ball_centroid.sv
// Directed bench for ball_centroid: table of single-frame vectors plus multi-cycle sequences.
module tb_ball_centroid;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_we;
  logic [15:0] pix_data;
  logic        frame_start;
  logic        res_valid;
  logic        res_ready;
  logic        res_found;
  logic [7:0]  res_x;
  logic [7:0]  res_y;
  logic [11:0] res_count;
  logic        overrun;

  always #5 clk = ~clk;

  ball_centroid dut (
    .clk         (clk),
    .rst         (rst),
    .pix_we      (pix_we),
    .pix_data    (pix_data),
    .frame_start (frame_start),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_found   (res_found),
    .res_x       (res_x),
    .res_y       (res_y),
    .res_count   (res_count),
    .overrun     (overrun)
  );

  typedef struct packed {
    logic [2:0]        n;
    logic [3:0][7:0]   px;
    logic [3:0][7:0]   py;
    logic [3:0][15:0]  col;
    logic              found;
    logic [7:0]        ex;
    logic [7:0]        ey;
    logic [11:0]       ecnt;
  } vec_t;

  vec_t vecs [5];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act != exp) $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [15:0] d);
    pix_we   = 1'b1;
    pix_data = d;
    tick();
    pix_we   = 1'b0;
    pix_data = 16'h0000;
  endtask

  // Raster-stream rows 0..max(py) of a 160-wide line; listed points get their colour.
  task automatic stream_vec(input vec_t v);
    int ymax = 0;
    logic [15:0] d;
    for (int p = 0; p < int'(v.n); p++) if (int'(v.py[p]) > ymax) ymax = int'(v.py[p]);
    for (int yy = 0; yy <= ymax; yy++) begin
      for (int xx = 0; xx < 160; xx++) begin
        d = 16'h0000;
        for (int p = 0; p < int'(v.n); p++)
          if (int'(v.px[p]) == xx && int'(v.py[p]) == yy) d = v.col[p];
        pix(d);
      end
    end
  endtask

  // Pulse frame_start (optionally with a ball pixel), wait for res_valid, check result.
  task automatic frame_check(input string nm, input bit with_pix, input int exp_lat,
                             input int exp_f, input int exp_x, input int exp_y,
                             input int exp_cnt);
    int lat;
    frame_start = 1'b1;
    if (with_pix) begin
      pix_we   = 1'b1;
      pix_data = 16'hF800;
    end
    tick();
    frame_start = 1'b0;
    pix_we      = 1'b0;
    pix_data    = 16'h0000;
    lat = 1;
    while (!res_valid && lat < 100) begin
      tick();
      lat++;
    end
    check({nm, " latency"}, lat, exp_lat);
    check({nm, " found"}, res_found, exp_f);
    check({nm, " x"}, res_x, exp_x);
    check({nm, " y"}, res_y, exp_y);
    check({nm, " count"}, res_count, exp_cnt);
  endtask

  task automatic accept(input string nm);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({nm, " valid after accept"}, res_valid, 0);
  endtask

  task automatic set_vec(input int i, input logic [2:0] n, input logic [3:0][7:0] px,
                         input logic [3:0][7:0] py, input logic [3:0][15:0] col,
                         input logic f, input logic [7:0] ex, input logic [7:0] ey,
                         input logic [11:0] c);
    vecs[i].n = n;
    vecs[i].px = px;
    vecs[i].py = py;
    vecs[i].col = col;
    vecs[i].found = f;
    vecs[i].ex = ex;
    vecs[i].ey = ey;
    vecs[i].ecnt = c;
  endtask

  initial begin
    int drops;
    rst = 1'b1;
    pix_we = 1'b0;
    pix_data = 16'h0000;
    frame_start = 1'b0;
    res_ready = 1'b0;

    // Four-corner square, three pixels, threshold colours, rejected colours, floor rounding.
    set_vec(0, 3'd4, {8'd12, 8'd10, 8'd12, 8'd10}, {8'd4, 8'd4, 8'd2, 8'd2},
            {16'hF800, 16'hF800, 16'hF800, 16'hF800}, 1'b1, 8'd11, 8'd3, 12'd4);
    set_vec(1, 3'd3, {8'd0, 8'd7, 8'd6, 8'd5}, {8'd0, 8'd0, 8'd0, 8'd0},
            {16'h0000, 16'hF800, 16'hF800, 16'hF800}, 1'b0, 8'd0, 8'd0, 12'd3);
    set_vec(2, 3'd4, {8'd159, 8'd0, 8'd159, 8'd0}, {8'd1, 8'd1, 8'd0, 8'd0},
            {16'hA30C, 16'hA30C, 16'hA30C, 16'hA30C}, 1'b1, 8'd79, 8'd0, 12'd4);
    set_vec(3, 3'd4, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd1, 8'd1, 8'd1, 8'd1},
            {16'hA30D, 16'hA32C, 16'h9B0C, 16'hF800}, 1'b0, 8'd0, 8'd0, 12'd1);
    set_vec(4, 3'd4, {8'd4, 8'd2, 8'd1, 8'd0}, {8'd5, 8'd0, 8'd0, 8'd0},
            {16'hF800, 16'hF800, 16'hF800, 16'hF800}, 1'b1, 8'd1, 8'd1, 12'd4);

    repeat (3) tick();
    rst = 1'b0;
    check("reset valid", res_valid, 0);
    check("reset found", res_found, 0);
    check("reset x", res_x, 0);
    check("reset y", res_y, 0);
    check("reset count", res_count, 0);
    check("reset overrun", overrun, 0);

    // Table: the first vector also covers pixels gathered before the first frame_start.
    for (int i = 0; i < 5; i++) begin
      stream_vec(vecs[i]);
      frame_check($sformatf("vec%0d", i), 1'b0, vecs[i].found ? 41 : 1, int'(vecs[i].found),
                  int'(vecs[i].ex), int'(vecs[i].ey), int'(vecs[i].ecnt));
      accept($sformatf("vec%0d", i));
    end

    // Held result with a discarded frame in between.
    for (int i = 0; i < 4; i++) pix(16'hF800);
    frame_check("hold", 1'b0, 41, 1, 1, 0, 4);
    drops = 0;
    for (int i = 0; i < 100; i++) begin
      if (i < 2) pix(16'hF800);
      else tick();
      if (!res_valid) drops++;
    end
    check("hold valid drops", drops, 0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("discard valid", res_valid, 1);
    check("discard found", res_found, 1);
    check("discard x", res_x, 1);
    check("discard count", res_count, 4);
    check("discard overrun", overrun, 1);
    for (int i = 0; i < 5; i++) pix(16'hF800);
    accept("discard");
    frame_check("after discard", 1'b0, 41, 1, 2, 0, 5);
    check("overrun sticky", overrun, 1);
    accept("after discard");

    // Pixel in the frame_start cycle belongs to the new frame at (0,0).
    for (int i = 0; i < 4; i++) pix(16'hF800);
    frame_check("samecyc old", 1'b1, 41, 1, 1, 0, 4);
    accept("samecyc old");
    frame_check("samecyc new", 1'b0, 1, 0, 0, 0, 1);
    accept("samecyc new");
    frame_check("samecyc empty", 1'b1, 1, 0, 0, 0, 0);
    accept("samecyc empty");
    for (int i = 0; i < 3; i++) pix(16'hF800);
    frame_check("samecyc xnext", 1'b0, 41, 1, 1, 0, 4);
    accept("samecyc xnext");

    // Count saturation: 4200 pixels, sums of the first 4095 only.
    for (int i = 0; i < 4200; i++) pix(16'hF800);
    frame_check("saturate", 1'b0, 41, 1, 78, 12, 4095);
    accept("saturate");

    // Reset during the x divide.
    for (int i = 0; i < 4; i++) pix(16'hF800);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (14) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst valid", res_valid, 0);
    check("midrst found", res_found, 0);
    check("midrst x", res_x, 0);
    check("midrst y", res_y, 0);
    check("midrst count", res_count, 0);
    check("midrst overrun", overrun, 0);
    drops = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (res_valid) drops++;
    end
    check("midrst no result", drops, 0);
    stream_vec(vecs[0]);
    frame_check("post reset", 1'b0, 41, 1, 11, 3, 4);
    accept("post reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
